// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate back-end: sums a programmed number of signed
// products onto a bias and presents one registered result per run.
module mac_accumulator #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 32,
   parameter int LEN_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [ACC_W-1:0] bias,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_product,
   output logic             busy,
   output logic             out_valid,
   output logic [ACC_W-1:0] acc_out,
   output logic             overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t             state_r;
   state_t             state_s;
   logic [LEN_W-1:0]   len_r;
   logic [LEN_W-1:0]   count_r;
   logic [ACC_W-1:0]   acc_r;
   logic [ACC_W:0]     sum_s;
   logic [ACC_W-1:0]   sat_s;
   logic               clamp_s;
   logic               accept_s;
   logic               last_s;
   logic               start_ok_s;

   assign start_ok_s = (state_r == IDLE) && start;
   assign accept_s   = (state_r == ACCUM) && in_valid;
   assign last_s     = accept_s && ((count_r + LEN_ONE) == len_r);

   // One guard bit catches signed overflow; clamp toward the sign of the true sum
   always_comb begin
      sum_s   = {acc_r[ACC_W-1], acc_r}
              + {{(ACC_W+1-IN_W){in_product[IN_W-1]}}, in_product};
      sat_s   = sum_s[ACC_W-1:0];
      clamp_s = 1'b0;
      if (sum_s[ACC_W] != sum_s[ACC_W-1]) begin
         clamp_s = 1'b1;
         sat_s   = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         clamp_s = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = (len != {LEN_W{1'b0}}) ? ACCUM : DONE;
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = ACCUM;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         len_r     <= {LEN_W{1'b0}};
         count_r   <= {LEN_W{1'b0}};
         acc_r     <= {ACC_W{1'b0}};
         acc_out   <= {ACC_W{1'b0}};
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_r   <= state_s;
         out_valid <= (state_r == DONE);
         if (start_ok_s) begin
            len_r    <= len;
            acc_r    <= bias;
            count_r  <= {LEN_W{1'b0}};
            overflow <= 1'b0;
            busy     <= 1'b1;
         end else if (accept_s) begin
            acc_r   <= sat_s;
            count_r <= count_r + LEN_ONE;
            if (clamp_s) begin
               overflow <= 1'b1;
            end
         end else if (state_r == DONE) begin
            acc_out <= acc_r;
            busy    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: default 32-bit instance plus a 20-bit
// accumulator instance for the saturation cases.
module tb_mac_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit accumulator instance
   logic        rst_a = 1'b1, start_a = 1'b0, vld_a = 1'b0;
   logic [11:0] len_a = 12'd0;
   logic [31:0] bias_a = 32'd0;
   logic [15:0] prod_a = 16'd0;
   logic        busy_a, ov_a, ovf_a;
   logic [31:0] acc_a;

   // 20-bit accumulator instance
   logic        rst_b = 1'b1, start_b = 1'b0, vld_b = 1'b0;
   logic [11:0] len_b = 12'd0;
   logic [19:0] bias_b = 20'd0;
   logic [15:0] prod_b = 16'd0;
   logic        busy_b, ov_b, ovf_b;
   logic [19:0] acc_b;

   mac_accumulator #(.IN_W(16), .ACC_W(32), .LEN_W(12)) u_a (
      .clk(clk), .rst(rst_a), .start(start_a), .len(len_a), .bias(bias_a),
      .in_valid(vld_a), .in_product(prod_a), .busy(busy_a),
      .out_valid(ov_a), .acc_out(acc_a), .overflow(ovf_a));

   mac_accumulator #(.IN_W(16), .ACC_W(20), .LEN_W(12)) u_b (
      .clk(clk), .rst(rst_b), .start(start_b), .len(len_b), .bias(bias_b),
      .in_valid(vld_b), .in_product(prod_b), .busy(busy_b),
      .out_valid(ov_b), .acc_out(acc_b), .overflow(ovf_b));

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_acc_a[$];
   logic        exp_ovf_a[$];
   logic [19:0] exp_acc_b[$];
   logic        exp_ovf_b[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act,
                  $signed(exp), exp);
      end
   endtask

   // Monitor for instance A: pop and compare on every result pulse
   always @(negedge clk) begin
      if (ov_a === 1'b1) begin
         if (exp_acc_a.size() == 0) begin
            chk("a_unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("a_acc_out", acc_a, exp_acc_a.pop_front());
            chk("a_overflow", {31'd0, ovf_a}, {31'd0, exp_ovf_a.pop_front()});
            chk("a_busy_low_at_result", {31'd0, busy_a}, 32'd0);
         end
      end
   end

   // Monitor for instance B
   always @(negedge clk) begin
      if (ov_b === 1'b1) begin
         if (exp_acc_b.size() == 0) begin
            chk("b_unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("b_acc_out", {{12{acc_b[19]}}, acc_b}, {{12{exp_acc_b[0][19]}}, exp_acc_b[0]});
            void'(exp_acc_b.pop_front());
            chk("b_overflow", {31'd0, ovf_b}, {31'd0, exp_ovf_b.pop_front()});
         end
      end
   end

   // One cycle of stimulus on instance A
   task automatic cyc_a(input logic st, input int l, input int b, input logic v, input int p);
      @(negedge clk);
      start_a = st; len_a = l[11:0]; bias_a = b[31:0];
      vld_a = v; prod_a = p[15:0];
   endtask

   task automatic cyc_b(input logic st, input int l, input int b, input logic v, input int p);
      @(negedge clk);
      start_b = st; len_b = l[11:0]; bias_b = b[19:0];
      vld_b = v; prod_b = p[15:0];
   endtask

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) cyc_a(1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic idle_b(input int n);
      for (int i = 0; i < n; i++) cyc_b(1'b0, 0, 0, 1'b0, 0);
   endtask

   task automatic run_a(input int l, input int b, input int exp, input logic eo);
      exp_acc_a.push_back(exp[31:0]);
      exp_ovf_a.push_back(eo);
      cyc_a(1'b1, l, b, 1'b0, 0);
   endtask

   initial begin
      int budget;
      // 1: reset state
      repeat (2) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("rst_acc_out", acc_a, 32'd0);
      chk("rst_out_valid", {31'd0, ov_a}, 32'd0);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_overflow", {31'd0, ovf_a}, 32'd0);

      // 2: back-to-back products, result one cycle after the last accept
      run_a(3, 0, 16309, 1'b0);
      cyc_a(1'b0, 0, 0, 1'b1, 200);
      chk("busy_after_start", {31'd0, busy_a}, 32'd1);
      cyc_a(1'b0, 0, 0, 1'b1, 16129);
      cyc_a(1'b0, 0, 0, 1'b1, -20);
      idle_a(1);
      chk("latency_not_early", {31'd0, ov_a}, 32'd0);
      idle_a(1);
      chk("latency_pulse", {31'd0, ov_a}, 32'd1);
      idle_a(1);
      chk("pulse_one_cycle", {31'd0, ov_a}, 32'd0);
      chk("acc_out_held", acc_a, 32'd16309);

      // 3: gaps stall the run; busy holds
      run_a(2, 100, 102, 1'b0);
      cyc_a(1'b0, 0, 0, 1'b1, -5);
      idle_a(3);
      chk("busy_through_gap", {31'd0, busy_a}, 32'd1);
      cyc_a(1'b0, 0, 0, 1'b1, 7);
      idle_a(3);

      // 4: zero-length run returns the bias; an IDLE product is ignored
      run_a(0, -42, -42, 1'b0);
      cyc_a(1'b0, 0, 0, 1'b1, 5);
      idle_a(4);

      // 5: saturation on the 20-bit instance
      exp_acc_b.push_back(20'h7FFFF); exp_ovf_b.push_back(1'b1);
      cyc_b(1'b1, 40, 0, 1'b0, 0);
      for (int i = 0; i < 40; i++) cyc_b(1'b0, 0, 0, 1'b1, 16129);
      idle_b(3);
      chk("b_ovf_sticky", {31'd0, ovf_b}, 32'd1);
      exp_acc_b.push_back(20'h80000); exp_ovf_b.push_back(1'b1);
      cyc_b(1'b1, 1, -524288, 1'b0, 0);
      cyc_b(1'b0, 0, 0, 1'b1, -1);
      idle_b(3);

      // 6: start during ACCUM is ignored
      run_a(4, 0, 10, 1'b0);
      cyc_a(1'b0, 0, 0, 1'b1, 1);
      cyc_a(1'b0, 0, 0, 1'b1, 2);
      cyc_a(1'b1, 1, 999, 1'b0, 0);
      cyc_a(1'b0, 0, 0, 1'b1, 3);
      cyc_a(1'b0, 0, 0, 1'b1, 4);
      idle_a(3);

      // 6: reset mid-run aborts without a result
      cyc_a(1'b1, 4, 0, 1'b0, 0);
      cyc_a(1'b0, 0, 0, 1'b1, 1);
      cyc_a(1'b0, 0, 0, 1'b1, 2);
      @(negedge clk); vld_a = 1'b0; rst_a = 1'b1;
      @(negedge clk); rst_a = 1'b0;
      chk("abort_busy", {31'd0, busy_a}, 32'd0);
      chk("abort_acc_out", acc_a, 32'd0);
      idle_a(4);
      run_a(1, 0, 10, 1'b0);
      cyc_a(1'b0, 0, 0, 1'b1, 10);
      idle_a(2);

      // Drain the scoreboards with a bounded wait
      budget = 0;
      while ((exp_acc_a.size() != 0 || exp_acc_b.size() != 0) && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      chk("a_all_results_seen", exp_acc_a.size(), 32'd0);
      chk("b_all_results_seen", exp_acc_b.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
